bpsk_mod_framer: RTL and testbench

BPSK_MOD_FRAMER -- requirements
Module: bpsk_mod_framer

---
 rtl/bpsk_mod_framer_pkg.sv | 17 +
 rtl/bpsk_mod_framer_if.sv | 24 ++
 rtl/bpsk_sym_map.sv | 12 +
 rtl/bpsk_mod_framer.sv | 81 ++++++++
 tb/tb_bpsk_mod_framer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_mod_framer_pkg.sv
// Shared definitions for the BPSK modulator family: state codes, symbol
// constants and the widest supported data word.
package bpsk_mod_framer_pkg;

  localparam int N_MAX = 15;

  // Antipodal two-chip symbols: a data 0 is sent as 01, a data 1 as 10.
  localparam logic [1:0] SYM_ZERO = 2'b01;
  localparam logic [1:0] SYM_ONE  = 2'b10;

  // Framer state enumeration, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t MAP  = 2'd1;
  localparam state_t HOLD = 2'd2;

endpackage

// File: rtl/bpsk_mod_framer_if.sv
// Word-in / symbol-word-out handshake bundle between a data source, the
// framer and the downstream demodulator or channel.
interface bpsk_mod_framer_if #(
  parameter int N = 8
);
  logic [N-1:0]   data_in;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] sym_out;
  logic           out_valid;
  logic           out_ready;

  // Framer side: consumes data words, produces symbol words.
  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, sym_out, out_valid
  );

  // Environment side: source of data words and sink of symbol words.
  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, sym_out, out_valid
  );
endinterface

// File: rtl/bpsk_sym_map.sv
// Single-bit BPSK mapper, shared by every modulator variant.
module bpsk_sym_map
  import bpsk_mod_framer_pkg::*;
(
  input  logic       bit_in,
  output logic [1:0] sym
);

  // Pure combinational lookup; no state.
  assign sym = bit_in ? SYM_ONE : SYM_ZERO;

endmodule

// File: rtl/bpsk_mod_framer.sv
// BPSK word framer: accepts an N-bit word, maps it LSB first into a 2N-bit
// symbol word one bit per cycle, then holds it until downstream takes it.
module bpsk_mod_framer
  import bpsk_mod_framer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  bpsk_mod_framer_if.slave   bus,
  output logic               busy,
  output logic [15:0]        word_count
);

  // Reject unsupported widths when the design is elaborated.
  generate
    if (N < 1 || N > N_MAX) begin : g_bad_n
      $error("bpsk_mod_framer: N must be in 1..%0d", N_MAX);
    end
  endgenerate

  state_t         state;
  logic [N-1:0]   shift_q;
  logic [3:0]     idx_q;
  logic [2*N-1:0] sym_q;
  logic [15:0]    word_count_q;
  logic [1:0]     cur_sym;

  // The bit currently at the bottom of the shift register is the one mapped.
  bpsk_sym_map u_map (
    .bit_in (shift_q[0]),
    .sym    (cur_sym)
  );

  // Handshake flags come straight from the registered state.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign busy          = (state != IDLE);
  assign bus.sym_out   = sym_q;
  assign word_count    = word_count_q;

  // Framing state machine with datapath; reset overrides any handshake.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register and symbol word are explicitly cleared so a
      // word in flight is fully discarded, not just invalidated by state.
      state        <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      sym_q        <= '0;
      word_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shift_q <= bus.data_in;
            sym_q   <= '0;
            idx_q   <= '0;
            state   <= MAP;
          end
        end
        MAP: begin
          sym_q[2*int'(idx_q) +: 2] <= cur_sym;
          shift_q <= shift_q >> 1;
          idx_q   <= idx_q + 4'd1;
          if (idx_q == 4'(N - 1)) state <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            state        <= IDLE;
            word_count_q <= word_count_q + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_mod_framer.sv
// Self-checking bench for bpsk_mod_framer: an N=8 instance carries most of
// the scenarios, an N=15 instance covers the widest word.
module tb_bpsk_mod_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy8, busy15;
  logic [15:0] wc8, wc15;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  bpsk_mod_framer_if #(.N(8))  bus8  ();
  bpsk_mod_framer_if #(.N(15)) bus15 ();

  bpsk_mod_framer #(.N(8)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8.slave), .busy (busy8), .word_count (wc8)
  );
  bpsk_mod_framer #(.N(15)) dut15 (
    .clk (clk), .rst (rst), .bus (bus15.slave), .busy (busy15), .word_count (wc15)
  );

  // Reference modulator: bit i of the word becomes chip pair i (1 -> 10, 0 -> 01).
  function automatic logic [29:0] exp_sym(input logic [14:0] d, input int n);
    logic [29:0] r = '0;
    for (int i = 0; i < n; i++) r = r | (30'(d[i] ? 2 : 1) << (2 * i));
    return r;
  endfunction

  // Reference demodulator: recovers data bits, flags any illegal chip pair.
  function automatic logic [14:0] demod(input logic [29:0] s, input int n, output bit ok);
    logic [14:0] d = '0;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      case ((s >> (2 * i)) & 30'd3)
        30'd2:   d[i] = 1'b1;
        30'd1:   d[i] = 1'b0;
        default: ok = 1'b0;
      endcase
    end
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;  bus8.data_in = '0;
    bus15.in_valid = 1'b0; bus15.out_ready = 1'b0; bus15.data_in = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pushes one word through dut8; edges counts clock edges from the accepting
  // edge up to the first cycle out_valid is seen.
  task automatic run_word8(input logic [7:0] d, output logic [15:0] sym, output int edges);
    @(negedge clk);
    bus8.data_in = d; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.data_in  = 8'($urandom);
    while (!bus8.out_valid && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    sym = bus8.sym_out;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
    total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
    total++; if (wc8 !== 16'd0) begin bad++; $display("FAIL reset_word_count: got %h want 0", wc8); end
    total++; if (bus8.sym_out !== 16'd0) begin bad++; $display("FAIL reset_sym_out: got %h want 0", bus8.sym_out); end
    total++; if (bus15.in_ready !== 1'b1 || busy15 !== 1'b0) begin bad++; $display("FAIL reset_n15: in_ready=%b busy=%b want 1/0", bus15.in_ready, busy15); end
  endtask

  task automatic test_mapping();
    logic [15:0] sym;
    int edges;
    run_word8(8'hA5, sym, edges);
    total++; if (sym !== 16'h9966) begin bad++; $display("FAIL map_a5: got %h want 9966", sym); end
    total++; if (edges !== 9) begin bad++; $display("FAIL map_latency: got %0d edges want 9", edges); end
    total++; if (wc8 !== 16'd1) begin bad++; $display("FAIL map_word_count: got %0d want 1", wc8); end
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL map_idle_after: in_ready=%b want 1", bus8.in_ready); end
  endtask

  task automatic test_mid_reset();
    logic [7:0]  d;
    logic [29:0] e;
    d = 8'($urandom);
    e = exp_sym(15'(d), 8);
    @(negedge clk);
    bus8.data_in = d; bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    // Two chip pairs mapped so far; the partial word is visible but not valid.
    total++; if (bus8.sym_out !== {12'd0, e[3:0]} || bus8.out_valid !== 1'b0) begin
      bad++; $display("FAIL partial_sym: got %h/%b want %h/0", bus8.sym_out, bus8.out_valid, {12'd0, e[3:0]});
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus8.in_ready !== 1'b1 || busy8 !== 1'b0) begin bad++; $display("FAIL midrst_state: in_ready=%b busy=%b want 1/0", bus8.in_ready, busy8); end
    total++; if (bus8.sym_out !== 16'd0 || bus8.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out: sym=%h valid=%b want 0/0", bus8.sym_out, bus8.out_valid); end
    total++; if (wc8 !== 16'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", wc8); end
    repeat (12) @(negedge clk);
    total++; if (bus8.out_valid !== 1'b0 || busy8 !== 1'b0) begin bad++; $display("FAIL midrst_dropped: valid=%b busy=%b want 0/0", bus8.out_valid, busy8); end
  endtask

  task automatic test_extremes();
    logic [15:0] sym;
    int edges;
    logic [29:0] s15;
    run_word8(8'h00, sym, edges);
    total++; if (sym !== 16'h5555) begin bad++; $display("FAIL ext_00: got %h want 5555", sym); end
    run_word8(8'hFF, sym, edges);
    total++; if (sym !== 16'hAAAA) begin bad++; $display("FAIL ext_ff: got %h want aaaa", sym); end
    // Widest word on the N=15 instance.
    @(negedge clk);
    bus15.data_in = 15'h7FFF; bus15.in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus15.in_valid = 1'b0; bus15.data_in = 15'($urandom);
    while (!bus15.out_valid && edges < 60) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    s15 = bus15.sym_out;
    total++; if (s15 !== 30'h2AAAAAAA) begin bad++; $display("FAIL ext_n15: got %h want 2aaaaaaa", s15); end
    total++; if (edges !== 16) begin bad++; $display("FAIL ext_n15_latency: got %0d edges want 16", edges); end
    bus15.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus15.out_ready = 1'b0;
    total++; if (wc15 !== 16'd1 || bus15.in_ready !== 1'b1) begin bad++; $display("FAIL ext_n15_done: count=%0d in_ready=%b want 1/1", wc15, bus15.in_ready); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  d;
    logic [15:0] held, want;
    logic [15:0] cnt0;
    int          waited;
    d    = 8'($urandom);
    want = 16'(exp_sym(15'(d), 8));
    cnt0 = wc8;
    @(negedge clk);
    bus8.data_in = d; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    waited = 0;
    while (!bus8.out_valid && waited < 40) begin @(posedge clk); waited++; @(negedge clk); end
    held = bus8.sym_out;
    total++; if (held !== want) begin bad++; $display("FAIL bp_sym: got %h want %h", held, want); end
    for (int c = 0; c < 5; c++) begin
      bus8.in_valid = 1'b1;
      bus8.data_in  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      total++; if (bus8.out_valid !== 1'b1 || bus8.sym_out !== want || bus8.in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d: valid=%b sym=%h in_ready=%b want 1/%h/0", c, bus8.out_valid, bus8.sym_out, bus8.in_ready, want);
      end
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.out_ready = 1'b0;
    total++; if (bus8.in_ready !== 1'b1 || busy8 !== 1'b0) begin bad++; $display("FAIL bp_release: in_ready=%b busy=%b want 1/0", bus8.in_ready, busy8); end
    total++; if (wc8 !== cnt0 + 16'd1) begin bad++; $display("FAIL bp_count: got %0d want %0d", wc8, cnt0 + 16'd1); end
    @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL bp_ignored_valid: busy=%b want 0", busy8); end
  endtask

  // Continuous traffic with out_ready held high: checks every word through
  // the reference demodulator and the N+2 cycle spacing between words.
  task automatic test_back_to_back();
    logic [7:0]  q[$];
    logic [7:0]  d, rec;
    logic [15:0] cnt0;
    bit          ok;
    int          last = -1;
    int          words = 0;
    cnt0 = wc8;
    @(negedge clk);
    bus8.out_ready = 1'b1;
    for (int c = 0; c < 150; c++) begin
      if (bus8.out_valid) begin
        if (q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_spurious: out_valid with nothing accepted at cycle %0d", c);
        end else begin
          d = q.pop_front();
          total++; if (bus8.sym_out !== 16'(exp_sym(15'(d), 8))) begin bad++; $display("FAIL b2b_sym: got %h want %h", bus8.sym_out, 16'(exp_sym(15'(d), 8))); end
          rec = 8'(demod(30'(bus8.sym_out), 8, ok));
          total++; if (!ok || rec !== d) begin bad++; $display("FAIL b2b_roundtrip: got %h want %h legal=%0d", rec, d, ok); end
          if (last >= 0) begin
            total++; if (c - last !== 10) begin bad++; $display("FAIL b2b_spacing: got %0d cycles want 10", c - last); end
          end
          last = c;
          words++;
        end
      end
      bus8.in_valid = (c < 120);
      bus8.data_in  = 8'($urandom);
      if (bus8.in_ready && bus8.in_valid) q.push_back(bus8.data_in);
      @(posedge clk);
      @(negedge clk);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    total++; if (q.size() !== 0 || words < 12) begin bad++; $display("FAIL b2b_drain: left=%0d words=%0d want 0/>=12", q.size(), words); end
    total++; if (wc8 !== cnt0 + 16'(words)) begin bad++; $display("FAIL b2b_count: got %0d want %0d", wc8, cnt0 + 16'(words)); end
  endtask

  // Preloads the counter to its last value, then one more handshake wraps it.
  task automatic test_wrap();
    logic [15:0] sym;
    int edges;
    @(negedge clk);
    force dut8.word_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut8.word_count_q;
    total++; if (wc8 !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", wc8); end
    run_word8(8'($urandom), sym, edges);
    total++; if (wc8 !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %h want 0000", wc8); end
  endtask

  initial begin
    test_reset();
    test_mapping();
    test_mid_reset();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
